// File: rtl/dro_sched_pkg.sv
// dro_sched_pkg: shared op encoding, FSM states and counter sizing for the DRO access scheduler
//   OP_WRITE / OP_READ : per-requester op encoding on req_op
//   state_t            : scheduler FSM states
//   cnt_w()            : bits needed to hold values 0..max_val (at least 1)
package dro_sched_pkg;
    localparam logic OP_WRITE = 1'b0;
    localparam logic OP_READ  = 1'b1;

    typedef enum logic [1:0] {ST_IDLE, ST_WR, ST_RD_CLK, ST_RD_WAIT} state_t;

    function automatic int cnt_w(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction
endpackage

// File: rtl/dro_rr_arb.sv
// dro_rr_arb: combinational round-robin pick of the first request at/after a pointer
//   req : candidate mask (already qualified by valid and eligibility)
//   ptr : index searched first
//   gnt : one-hot winner, idx : winner index, any : a winner exists
module dro_rr_arb #(
    parameter int N  = 2,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          any
);
    logic [IW-1:0] j;

    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        j   = '0;
        for (int i = 0; i < N; i++) begin
            j = IW'((int'(ptr) + i) % N);
            if (!any && req[j]) begin
                any    = 1'b1;
                idx    = j;
                gnt[j] = 1'b1;
            end
        end
    end
endmodule

// File: rtl/dro_access_sched.sv
// dro_access_sched: round-robin scheduler sharing one DRO cell among N_REQ requesters
//   clk, rst                   : clock, synchronous active-high reset
//   req_valid/req_op/req_bit   : per-requester request, op (0=WRITE,1=READ), write data
//   gnt                        : one-hot 1-cycle grant
//   rsp_valid/rsp_bit          : one-hot 1-cycle completion, READ result
//   d_pulse/clk_pulse          : 1-cycle pulses to DRO d / clk
//   dro_out                    : DRO output pulse
//   busy                       : op in flight
//   viol/viol_cnt              : stray dro_out flag and saturating count
module dro_access_sched
    import dro_sched_pkg::*;
#(
    parameter int N_REQ     = 2,
    parameter int SETUP_CYC = 3,
    parameter int HOLD_CYC  = 2,
    parameter int OUT_LAT   = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req_valid,
    input  logic [N_REQ-1:0] req_op,
    input  logic [N_REQ-1:0] req_bit,
    output logic [N_REQ-1:0] gnt,
    output logic [N_REQ-1:0] rsp_valid,
    output logic             rsp_bit,
    output logic             d_pulse,
    output logic             clk_pulse,
    input  logic             dro_out,
    output logic             busy,
    output logic             viol,
    output logic [7:0]       viol_cnt
);
    localparam int CMAX = (SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC;
    localparam int CW   = cnt_w(CMAX);
    localparam int IW   = $clog2(N_REQ);
    localparam int LW   = cnt_w(OUT_LAT - 1);

    state_t          state, state_n;
    logic [IW-1:0]   ptr, cur_idx, arb_idx;
    logic            cur_bit, arb_any, last_wait, stray, seen;
    logic [N_REQ-1:0] elig, arb_req;
    logic [CW-1:0]   since_d, since_clk;
    logic [LW-1:0]   wait_cnt;

    // A requester competes only when its op would not break the pulse spacing.
    always_comb begin
        elig = '0;
        for (int i = 0; i < N_REQ; i++)
            elig[i] = req_valid[i] && ((req_op[i] == OP_READ) ? (since_d >= CW'(SETUP_CYC))
                                                              : (since_clk >= CW'(HOLD_CYC)));
    end

    assign arb_req = (state == ST_IDLE && !rst) ? elig : '0;

    dro_rr_arb #(.N(N_REQ), .IW(IW)) u_arb (
        .req (arb_req),
        .ptr (ptr),
        .gnt (gnt),
        .idx (arb_idx),
        .any (arb_any)
    );

    assign last_wait = (state == ST_RD_WAIT) && (wait_cnt == LW'(OUT_LAT - 1));
    // Anything on dro_out outside the post-clk sample window is a violation.
    assign stray     = dro_out && (state != ST_RD_WAIT);

    always_comb begin
        state_n   = state;
        d_pulse   = 1'b0;
        clk_pulse = 1'b0;
        busy      = 1'b0;
        rsp_valid = '0;
        rsp_bit   = 1'b0;
        case (state)
            ST_IDLE:    state_n = arb_any ? ((req_op[arb_idx] == OP_READ) ? ST_RD_CLK : ST_WR) : ST_IDLE;
            ST_WR:      state_n = ST_IDLE;
            ST_RD_CLK:  state_n = ST_RD_WAIT;
            ST_RD_WAIT: state_n = last_wait ? ST_IDLE : ST_RD_WAIT;
            default:    state_n = ST_IDLE;
        endcase
        d_pulse   = (state == ST_WR) && cur_bit;
        clk_pulse = (state == ST_RD_CLK);
        busy      = (state != ST_IDLE);
        rsp_valid = ((state == ST_WR) || last_wait) ? (N_REQ'(1) << cur_idx) : '0;
        // The last window cycle counts too, so fold in the live dro_out.
        rsp_bit   = last_wait && (seen || dro_out);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            ptr       <= '0;
            cur_idx   <= '0;
            cur_bit   <= 1'b0;
            since_d   <= CW'(CMAX);
            since_clk <= CW'(CMAX);
            wait_cnt  <= '0;
            seen      <= 1'b0;
            viol      <= 1'b0;
            viol_cnt  <= '0;
        end else begin
            state <= state_n;
            if (arb_any) begin
                cur_idx <= arb_idx;
                cur_bit <= req_bit[arb_idx];
                ptr     <= (arb_idx == IW'(N_REQ - 1)) ? '0 : arb_idx + 1'b1;
            end
            since_d   <= d_pulse ? CW'(1) : ((since_d == CW'(CMAX)) ? since_d : since_d + 1'b1);
            since_clk <= clk_pulse ? CW'(1) : ((since_clk == CW'(CMAX)) ? since_clk : since_clk + 1'b1);
            wait_cnt  <= (state == ST_RD_WAIT) ? wait_cnt + 1'b1 : '0;
            seen      <= (state == ST_RD_WAIT) && (seen || dro_out);
            viol      <= stray;
            viol_cnt  <= viol_cnt + {7'd0, stray && (viol_cnt != 8'hFF)};
        end
    end
endmodule

// File: tb/tb_dro_access_sched.sv
// tb_dro_access_sched: scoreboard and vector-table bench for dro_access_sched
`timescale 1ns/1ps
module tb_dro_access_sched;
    localparam int SETUP = 3;
    localparam int HOLD  = 2;
    localparam int LAT   = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] req_valid = '0, req_op = '0, req_bit = '0;
    logic [1:0] gnt, rsp_valid;
    logic       rsp_bit, d_pulse, clk_pulse, dro_out, busy, viol;
    logic [7:0] viol_cnt;
    logic       dro_st = 1'b0, echo = 1'b0, inject = 1'b0;

    dro_access_sched #(.N_REQ(2), .SETUP_CYC(SETUP), .HOLD_CYC(HOLD), .OUT_LAT(LAT)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_op(req_op), .req_bit(req_bit),
        .gnt(gnt), .rsp_valid(rsp_valid), .rsp_bit(rsp_bit), .d_pulse(d_pulse),
        .clk_pulse(clk_pulse), .dro_out(dro_out), .busy(busy), .viol(viol), .viol_cnt(viol_cnt)
    );

    always #5 clk = ~clk;

    // DRO cell model: d sets it, clk reads it destructively and echoes one cycle later.
    assign dro_out = echo | inject;
    always @(posedge clk) begin
        echo <= clk_pulse & dro_st;
        if (clk_pulse) dro_st <= 1'b0;
        else if (d_pulse) dro_st <= 1'b1;
    end

    typedef struct {int idx; bit rd; bit exp_bit; bit exp_dp;} exp_t;
    typedef struct {int idx; bit rd; bit b; bit exp_bit;} vec_t;
    exp_t sb[$];
    vec_t tbl[12];

    int checks = 0, errors = 0, cyc = 0;
    int g_cyc = -100, last_d = -100, last_clk = -100;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk_eq(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk_ok(input string name, input bit ok, input int act, input int req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0d required %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            last_d   = -100;
            last_clk = -100;
        end else begin
            if (d_pulse || clk_pulse) chk_eq("pulse_overlap", int'(d_pulse & clk_pulse), 0);
            if (clk_pulse) begin
                chk_ok("setup_spacing", cyc - last_d >= SETUP, cyc - last_d, SETUP);
                last_clk = cyc;
            end
            if (d_pulse) begin
                chk_ok("hold_spacing", cyc - last_clk >= HOLD, cyc - last_clk, HOLD);
                last_d = cyc;
            end
            if (|gnt) begin
                chk_eq("gnt_onehot", $countones(gnt), 1);
                g_cyc = cyc;
            end
            if (|rsp_valid) begin
                if (sb.size() == 0) chk_eq("rsp_unexpected", int'(rsp_valid), 0);
                else begin
                    e = sb.pop_front();
                    chk_eq("rsp_idx", int'(rsp_valid), 1 << e.idx);
                    chk_eq("rsp_latency", cyc - g_cyc, e.rd ? 1 + LAT : 1);
                    if (e.rd) chk_eq("rsp_bit", int'(rsp_bit), int'(e.exp_bit));
                    else chk_eq("wr_d_pulse", int'(d_pulse), int'(e.exp_dp));
                end
            end
        end
    end

    task automatic wait_gnt(input int idx);
        bit ok = 1'b0;
        for (int k = 0; k < 50 && !ok; k++) begin
            @(negedge clk);
            ok = gnt[idx];
        end
        chk_ok("gnt_wait", ok, int'(ok), 1);
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int k = 0; k < 50 && !ok; k++) begin
            @(negedge clk);
            ok = !busy;
        end
        chk_ok("idle_wait", ok, int'(ok), 1);
    endtask

    task automatic do_op(input int idx, input bit rd, input bit b, input bit exp_bit);
        sb.push_back('{idx, rd, exp_bit, b});
        @(posedge clk); #1;
        req_op[idx]    = rd;
        req_bit[idx]   = b;
        req_valid[idx] = 1'b1;
        wait_gnt(idx);
        @(posedge clk); #1;
        req_valid[idx] = 1'b0;
        wait_idle();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit ok;
        tbl = '{'{0, 0, 0, 0}, '{0, 1, 0, 0}, '{0, 0, 1, 0}, '{0, 1, 0, 1},
                '{1, 1, 0, 0}, '{1, 0, 1, 0}, '{0, 0, 0, 0}, '{1, 1, 0, 1},
                '{1, 0, 1, 0}, '{1, 0, 1, 0}, '{0, 1, 0, 1}, '{0, 1, 0, 0}};

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk_eq("idle_outputs", int'({gnt, rsp_valid, rsp_bit, d_pulse, clk_pulse, busy, viol}), 0);
            chk_eq("idle_viol_cnt", int'(viol_cnt), 0);
        end

        // WRITE 1 then READ right away from the same requester
        sb.push_back('{0, 1'b0, 1'b0, 1'b1});
        sb.push_back('{0, 1'b1, 1'b1, 1'b0});
        @(posedge clk); #1;
        req_op[0] = 1'b0; req_bit[0] = 1'b1; req_valid[0] = 1'b1;
        wait_gnt(0);
        @(posedge clk); #1;
        req_op[0] = 1'b1;
        wait_gnt(0);
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        wait_idle();
        chk_ok("setup_wr_then_rd", last_clk - last_d >= SETUP, last_clk - last_d, SETUP);

        for (int i = 0; i < 12; i++) do_op(tbl[i].idx, tbl[i].rd, tbl[i].b, tbl[i].exp_bit);

        // READ on req0 just granted, WRITE on req1 arrives behind it
        sb.push_back('{0, 1'b1, 1'b0, 1'b0});
        sb.push_back('{1, 1'b0, 1'b0, 1'b1});
        @(posedge clk); #1;
        req_op[0] = 1'b1; req_valid[0] = 1'b1;
        wait_gnt(0);
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        req_op[1] = 1'b0; req_bit[1] = 1'b1; req_valid[1] = 1'b1;
        wait_gnt(1);
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        wait_idle();
        chk_ok("hold_rd_then_wr", last_d - last_clk >= HOLD, last_d - last_clk, HOLD);

        // Both requesters READ back-to-back; first read consumes the 1 just written
        for (int i = 0; i < 8; i++) sb.push_back('{i % 2, 1'b1, i == 0, 1'b0});
        @(posedge clk); #1;
        req_op = 2'b11; req_valid = 2'b11;
        for (int i = 0; i < 8; i++) begin
            ok = 1'b0;
            for (int k = 0; k < 50 && !ok; k++) begin
                @(negedge clk);
                ok = |gnt;
            end
            chk_eq("rr_order", int'(gnt), 1 << (i % 2));
        end
        @(posedge clk); #1;
        req_valid = 2'b00;
        wait_idle();

        // Reset in the middle of a READ wait window
        @(posedge clk); #1;
        req_op[0] = 1'b1; req_valid[0] = 1'b1;
        wait_gnt(0);
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        @(posedge clk); #1;
        chk_eq("in_rd_wait", int'(busy), 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk_eq("rst_busy", int'(busy), 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk_eq("rst_no_rsp", int'(rsp_valid), 0);
        end

        chk_eq("viol_cnt_pre", int'(viol_cnt), 0);
        for (int k = 1; k <= 300; k++) begin
            @(posedge clk); #1;
            inject = 1'b1;
            @(posedge clk); #1;
            inject = 1'b0;
            chk_eq("viol_pulse", int'(viol), 1);
            chk_eq("viol_cnt", int'(viol_cnt), (k > 255) ? 255 : k);
        end
        @(posedge clk); #1;
        chk_eq("viol_clear", int'(viol), 0);

        chk_eq("sb_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
